// File: rtl/iterative_divider_if.sv
// Divide request/response bundle between the execute stage (master) and
// the iterative divider (slave).
//
// Handshake: execute raises enable with op/rdata1/rdata2 and holds all four
// stable until it observes ready=1. Ready is a one-cycle pulse, and result is
// valid only while ready is high. Dropping enable before ready appears
// cancels the request.
interface iterative_divider_if #(
    parameter int XLEN = 32
);
    logic            enable;
    logic [1:0]      op;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [XLEN-1:0] result;
    logic            ready;

    modport master (
        output enable, op, rdata1, rdata2,
        input  result, ready
    );

    modport slave (
        input  enable, op, rdata1, rdata2,
        output result, ready
    );
endinterface

// File: rtl/iterative_divider.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Signed operands are converted to magnitudes on entry, and signs are
// reapplied once at the end. Divide-by-zero and signed overflow finish in one
// cycle without iterating.
module iterative_divider #(
    parameter int XLEN = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    iterative_divider_if.slave   bus,
    output logic [1:0]           state_o
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   counter_q;
    logic [XLEN-1:0] rem_q;      // partial remainder
    logic [XLEN-1:0] quo_q;      // dividend shifting out, quotient shifting in
    logic [XLEN-1:0] dvs_q;      // divisor magnitude
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic            rem_sel_q;  // op[1]: return the remainder, not the quotient
    logic [XLEN-1:0] result_q;
    logic            ready_q;

    logic            signed_op, sign1, sign2, div_zero, overflow;
    logic [XLEN-1:0] abs1, abs2, fast_res;
    logic [XLEN:0]   rem_shift, diff;
    logic            fits;
    logic [XLEN-1:0] rem_d, quo_d, fin_quo, fin_rem, final_res;

    // Operand decode for the IDLE accept decision and the fast-path results.
    always_comb begin
        signed_op = ~bus.op[0];
        sign1     = signed_op & bus.rdata1[XLEN-1];
        sign2     = signed_op & bus.rdata2[XLEN-1];
        abs1      = sign1 ? (XLEN'(0) - bus.rdata1) : bus.rdata1;
        abs2      = sign2 ? (XLEN'(0) - bus.rdata2) : bus.rdata2;
        div_zero  = (bus.rdata2 == '0);
        overflow  = signed_op && (bus.rdata1 == MIN_NEG) && (bus.rdata2 == '1);
        fast_res  = '0;
        if (div_zero) begin
            fast_res = bus.op[1] ? bus.rdata1 : '1;
        end else if (overflow) begin
            fast_res = bus.op[1] ? '0 : MIN_NEG;
        end
    end

    // One restoring step. The extra top bit of the compare keeps the
    // subtraction from wrapping, so its borrow decides the quotient bit.
    always_comb begin
        rem_shift = {rem_q, quo_q[XLEN-1]};
        diff      = rem_shift - {1'b0, dvs_q};
        fits      = ~diff[XLEN];
        rem_d     = fits ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
        quo_d     = {quo_q[XLEN-2:0], fits};
        fin_quo   = neg_quo_q ? (XLEN'(0) - quo_d) : quo_d;
        fin_rem   = neg_rem_q ? (XLEN'(0) - rem_d) : rem_d;
        final_res = rem_sel_q ? fin_rem : fin_quo;
    end

    // Control FSM and datapath registers. Result and ready are set on the
    // edge that enters DONE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            counter_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_sel_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (bus.enable) begin
                        if (div_zero || overflow) begin
                            result_q <= fast_res;
                            ready_q  <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            quo_q     <= abs1;
                            dvs_q     <= abs2;
                            rem_q     <= '0;
                            neg_quo_q <= sign1 ^ sign2;
                            neg_rem_q <= sign1;
                            rem_sel_q <= bus.op[1];
                            counter_q <= '0;
                            state_q   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (!bus.enable) begin
                        state_q <= IDLE;  // flush: no pulse, result kept
                    end else begin
                        rem_q     <= rem_d;
                        quo_q     <= quo_d;
                        counter_q <= counter_q + CW'(1);
                        if (counter_q == CW'(XLEN - 1)) begin
                            result_q <= final_res;
                            ready_q  <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                end
                DONE: begin
                    // The held request is deliberately not restarted here.
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.ready  = ready_q;
    assign state_o    = state_q;
endmodule

// File: tb/tb_iterative_divider.sv
// Directed testbench for iterative_divider: a table of hand-computed vectors
// followed by hand-written flush, reset and back-to-back sequences.
module tb_iterative_divider;
    localparam int XLEN = 32;
    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    logic       clock;
    logic       reset;
    logic [1:0] state_dbg;

    iterative_divider_if #(.XLEN(XLEN)) dif ();

    iterative_divider #(.XLEN(XLEN)) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (dif.slave),
        .state_o (state_dbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] last_result;

    typedef struct {
        string           name;
        logic [1:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp;
        int              lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // driver: issue one request, hold enable until ready is seen, check the
    // pulse cycle, pulse count and result against the scoreboard.
    task automatic run_req(input string name, input logic [1:0] op, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int lat);
        int pulses = 0;
        int seen_at = -1;
        logic [XLEN-1:0] got = '0;
        logic [XLEN-1:0] want;
        exp_q.push_back(exp);
        @(negedge clock);
        dif.enable = 1'b1;
        dif.op     = op;
        dif.rdata1 = a;
        dif.rdata2 = b;
        for (int k = 1; k <= lat + 4; k++) begin
            @(posedge clock);
            #1;
            if (dif.ready === 1'b1) begin
                pulses++;
                if (seen_at < 0) begin
                    seen_at = k;
                    got = dif.result;
                end
                dif.enable = 1'b0;
            end
        end
        dif.enable = 1'b0;
        want = exp_q.pop_front();
        check({name, " pulses"}, XLEN'(pulses), XLEN'(1));
        check({name, " latency"}, XLEN'(seen_at), XLEN'(lat));
        check({name, " result"}, got, want);
        last_result = want;
    endtask

    initial begin
        dif.enable = 1'b0;
        dif.op     = OP_DIVU;
        dif.rdata1 = '0;
        dif.rdata2 = '0;
        reset      = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset ready", XLEN'(dif.ready), '0);
        check("reset result", dif.result, '0);
        check("reset state", XLEN'(state_dbg), '0);
        @(negedge clock);
        reset = 1'b1;

        vecs.push_back('{"divu 100/7",      OP_DIVU, 32'd100,      32'd7,          32'd14,       33});
        vecs.push_back('{"rem -7/2",        OP_REM,  32'hFFFFFFF9, 32'd2,          32'hFFFFFFFF, 33});
        vecs.push_back('{"div -7/2",        OP_DIV,  32'hFFFFFFF9, 32'd2,          32'hFFFFFFFD, 33});
        vecs.push_back('{"divu x/0",        OP_DIVU, 32'h12345678, 32'd0,          32'hFFFFFFFF, 1});
        vecs.push_back('{"remu x/0",        OP_REMU, 32'h12345678, 32'd0,          32'h12345678, 1});
        vecs.push_back('{"div ovf",         OP_DIV,  32'h80000000, 32'hFFFFFFFF,   32'h80000000, 1});
        vecs.push_back('{"rem ovf",         OP_REM,  32'h80000000, 32'hFFFFFFFF,   32'h00000000, 1});
        vecs.push_back('{"divu min/-1",     OP_DIVU, 32'h80000000, 32'hFFFFFFFF,   32'h00000000, 33});
        vecs.push_back('{"remu max/16",     OP_REMU, 32'hFFFFFFFF, 32'd16,         32'h0000000F, 33});
        vecs.push_back('{"div 7/-2",        OP_DIV,  32'd7,        32'hFFFFFFFE,   32'hFFFFFFFD, 33});
        vecs.push_back('{"rem 7/-2",        OP_REM,  32'd7,        32'hFFFFFFFE,   32'h00000001, 33});
        vecs.push_back('{"div -100/-7",     OP_DIV,  32'hFFFFFF9C, 32'hFFFFFFF9,   32'd14,       33});
        vecs.push_back('{"rem -100/-7",     OP_REM,  32'hFFFFFF9C, 32'hFFFFFFF9,   32'hFFFFFFFE, 33});
        vecs.push_back('{"div min/2",       OP_DIV,  32'h80000000, 32'd2,          32'hC0000000, 33});
        vecs.push_back('{"divu max/1",      OP_DIVU, 32'hFFFFFFFF, 32'd1,          32'hFFFFFFFF, 33});
        vecs.push_back('{"rem 0/0",         OP_REM,  32'd0,        32'd0,          32'd0,        1});

        foreach (vecs[i]) begin
            run_req(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        // flush: drop enable at iteration 10, expect no pulse and result kept
        begin
            int pulses = 0;
            @(negedge clock);
            dif.enable = 1'b1;
            dif.op     = OP_DIVU;
            dif.rdata1 = 32'd1000;
            dif.rdata2 = 32'd3;
            for (int k = 1; k <= 40; k++) begin
                @(posedge clock);
                #1;
                if (dif.ready === 1'b1) pulses++;
                if (k == 10) dif.enable = 1'b0;
            end
            check("flush pulses", XLEN'(pulses), '0);
            check("flush state idle", XLEN'(state_dbg), '0);
            check("flush result kept", dif.result, last_result);
        end
        run_req("divu 9/3 after flush", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

        // reset in the middle of BUSY
        @(negedge clock);
        dif.enable = 1'b1;
        dif.op     = OP_DIVU;
        dif.rdata1 = 32'd50;
        dif.rdata2 = 32'd5;
        repeat (6) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("midreset ready", XLEN'(dif.ready), '0);
        check("midreset result", dif.result, '0);
        check("midreset state", XLEN'(state_dbg), '0);
        dif.enable = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        // back-to-back with enable held continuously
        begin
            int pulses = 0;
            int at[2] = '{-1, -1};
            logic [XLEN-1:0] res[2] = '{'0, '0};
            exp_q.push_back(32'd10);
            exp_q.push_back(32'd9);
            @(negedge clock);
            dif.enable = 1'b1;
            dif.op     = OP_DIVU;
            dif.rdata1 = 32'd50;
            dif.rdata2 = 32'd5;
            for (int k = 1; k <= 75; k++) begin
                @(posedge clock);
                #1;
                if (dif.ready === 1'b1) begin
                    if (pulses < 2) begin
                        at[pulses]  = k;
                        res[pulses] = dif.result;
                    end
                    pulses++;
                    if (pulses == 1) begin
                        dif.rdata1 = 32'd81;
                        dif.rdata2 = 32'd9;
                    end else begin
                        dif.enable = 1'b0;
                    end
                end
            end
            dif.enable = 1'b0;
            check("b2b pulses", XLEN'(pulses), XLEN'(2));
            check("b2b first latency", XLEN'(at[0]), XLEN'(33));
            check("b2b spacing", XLEN'(at[1] - at[0]), XLEN'(34));
            check("b2b first result", res[0], exp_q.pop_front());
            check("b2b second result", res[1], exp_q.pop_front());
        end

        repeat (2) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // time limit: the directed run is a few thousand cycles at most
    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end
endmodule
